// File: rtl/lu_band_collector.sv
// Band collector for the 8x8 LU systolic factorizer: captures the skewed diagonal
// lanes into per-diagonal storage, then serves L/U as addressable matrices.

module lu_band_lane #(
  parameter int iSZ    = 8,
  parameter int OFF    = 0,
  parameter int LEN    = 8,
  parameter int T0     = 4,
  parameter int PERIOD = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cap_i,
  input  logic [4:0]     c_i,
  input  logic [iSZ-1:0] din_i,
  input  logic [2:0]     rd_idx_i,
  output logic [iSZ-1:0] rd_word_o
);
  localparam logic [4:0] BASE = 5'(T0 + OFF);
  localparam logic [4:0] P5   = 5'(PERIOD);

  logic [iSZ-1:0] mem_q [LEN];
  logic [4:0]     d;
  logic           hit;
  logic [2:0]     j;

  // Lane samples every PERIOD cycles starting at T0+OFF, for LEN entries.
  always_comb begin
    d   = c_i - BASE;
    j   = 3'(d / P5);
    hit = cap_i && (c_i >= BASE) && ((d % P5) == 5'd0) && ((d / P5) < 5'(LEN));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LEN; i++) mem_q[i] <= '0;
    end else if (hit) begin
      mem_q[j] <= din_i;
    end
  end

  assign rd_word_o = (32'(rd_idx_i) < LEN) ? mem_q[rd_idx_i] : '0;
endmodule

module lu_band_collector #(
  parameter int iSZ    = 8,
  parameter int N      = 8,
  parameter int T0     = 4,
  parameter int PERIOD = 3,
  parameter int ONE    = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [iSZ-1:0] lL1,
  input  logic [iSZ-1:0] lL2,
  input  logic [iSZ-1:0] lL3,
  input  logic [iSZ-1:0] uL1,
  input  logic [iSZ-1:0] uL2,
  input  logic [iSZ-1:0] uL3,
  input  logic [iSZ-1:0] uL4,
  output logic           busy,
  output logic           ready,
  output logic           done,
  input  logic           rd_en,
  input  logic           rd_sel,
  input  logic [2:0]     rd_row,
  input  logic [2:0]     rd_col,
  output logic [iSZ-1:0] rd_data,
  output logic           rd_valid
);
  localparam int         NUM_LANES = 7;
  localparam logic [4:0] C_LAST    = 5'(T0 + PERIOD * (N - 1));

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t state_q, state_d;
  logic [4:0] c_q, c_d;
  logic done_q, done_d;
  logic [iSZ-1:0] rd_data_q;
  logic rd_valid_q;

  // Lanes 0..3 are U super-diagonals 0..3, lanes 4..6 are L sub-diagonals 1..3.
  logic [NUM_LANES-1:0][iSZ-1:0] lane_din, lane_word;
  assign lane_din = {lL3, lL2, lL1, uL4, uL3, uL2, uL1};

  logic       cap;
  logic [2:0] rd_idx, lane_sel;
  logic       use_store;
  logic [iSZ-1:0] rd_val;

  assign cap = (state_q == CAPTURE);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam int OFF = (g < 4) ? g : g - 3;
    lu_band_lane #(
      .iSZ(iSZ), .OFF(OFF), .LEN(N - OFF), .T0(T0), .PERIOD(PERIOD)
    ) u_lane (
      .clk(clk), .rst_n(rst_n), .cap_i(cap), .c_i(c_q),
      .din_i(lane_din[g]), .rd_idx_i(rd_idx), .rd_word_o(lane_word[g])
    );
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:    if (start) begin state_d = CAPTURE; c_d = '0; end
      CAPTURE: begin
        c_d = c_q + 5'd1;
        if (c_q == C_LAST) begin state_d = DONE; done_d = 1'b1; end
      end
      DONE:    if (start) begin state_d = CAPTURE; c_d = '0; end
      default: state_d = IDLE;
    endcase
  end

  // Read decode: band position selects lane; entry index is col for L, row for U.
  always_comb begin
    rd_idx    = '0;
    lane_sel  = '0;
    use_store = 1'b0;
    rd_val    = '0;
    if (!rd_sel) begin
      if (rd_row == rd_col) begin
        rd_val = iSZ'(ONE);
      end else if (rd_row > rd_col && (rd_row - rd_col) <= 3'd3) begin
        use_store = 1'b1;
        lane_sel  = 3'd3 + (rd_row - rd_col);
        rd_idx    = rd_col;
      end
    end else if (rd_col >= rd_row && (rd_col - rd_row) <= 3'd3) begin
      use_store = 1'b1;
      lane_sel  = rd_col - rd_row;
      rd_idx    = rd_row;
    end
    if (use_store) rd_val = lane_word[lane_sel];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      c_q        <= '0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      c_q        <= c_d;
      done_q     <= done_d;
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= rd_val;
    end
  end

  assign busy     = cap;
  assign ready    = (state_q == DONE);
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
endmodule

// File: tb/tb_lu_band_collector.sv
// Directed bench for lu_band_collector: capture runs, band-edge reads, restart,
// ignored start, read/capture collision and mid-capture reset.

module tb_lu_band_collector;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] lL1 = 8'hFF, lL2 = 8'hFF, lL3 = 8'hFF;
  logic [7:0] uL1 = 8'hFF, uL2 = 8'hFF, uL3 = 8'hFF, uL4 = 8'hFF;
  logic       busy, ready, done;
  logic       rd_en = 1'b0, rd_sel = 1'b0;
  logic [2:0] rd_row = '0, rd_col = '0;
  logic [7:0] rd_data;
  logic       rd_valid;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lu_band_collector dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .lL1(lL1), .lL2(lL2), .lL3(lL3),
    .uL1(uL1), .uL2(uL2), .uL3(uL3), .uL4(uL4),
    .busy(busy), .ready(ready), .done(done),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_row(rd_row), .rd_col(rd_col),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  // Pattern value for a lane at cycle c: (id<<4)|j on its sample cycles, else 0xFF.
  function automatic logic [7:0] pat(input int id, input int off, input int len, input int c);
    int d;
    d = c - 4 - off;
    if (d >= 0 && d % 3 == 0 && d / 3 < len) return 8'((id << 4) | (d / 3));
    return 8'hFF;
  endfunction

  task automatic drive_lanes(input int c, input bit flat_aa);
    if (flat_aa) begin
      {uL1, uL2, uL3, uL4, lL1, lL2, lL3} = {7{8'hAA}};
    end else begin
      uL1 = pat(0, 0, 8, c); uL2 = pat(1, 1, 7, c);
      uL3 = pat(2, 2, 6, c); uL4 = pat(3, 3, 5, c);
      lL1 = pat(5, 1, 7, c); lL2 = pat(6, 2, 6, c); lL3 = pat(7, 3, 5, c);
    end
  endtask

  // Read one cell: rd_valid/rd_data one cycle after rd_en, rd_valid low after that.
  task automatic do_read(input bit sel, input int row, input int col,
                         input logic [7:0] exp, input string name);
    @(negedge clk);
    rd_en = 1'b1; rd_sel = sel; rd_row = 3'(row - 1); rd_col = 3'(col - 1);
    @(negedge clk);
    rd_en = 1'b0;
    n_assert++;
    if (rd_valid !== 1'b1) begin
      n_fail++; $display("FAIL %s rd_valid: got %b expected 1", name, rd_valid);
    end
    n_assert++;
    if (rd_data !== exp) begin
      n_fail++; $display("FAIL %s rd_data: got %h expected %h", name, rd_data, exp);
    end
    @(negedge clk);
    n_assert++;
    if (rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s rd_valid drop: got %b expected 0", name, rd_valid);
    end
  endtask

  // One capture run. Optional stray start at c=10 and optional U(1,1) read at c=rd_at.
  task automatic run_capture(input bit flat_aa, input bit stray_start,
                             input int rd_at, input logic [7:0] rd_exp, input string name);
    @(negedge clk);
    drive_lanes(-10, flat_aa);
    start = 1'b1;
    for (int c = 0; c <= 27; c++) begin
      @(negedge clk);
      start = (stray_start && c == 10);
      drive_lanes(c, flat_aa);
      n_assert++;
      if (done !== (c == 26)) begin
        n_fail++; $display("FAIL %s done c=%0d: got %b expected %b", name, c, done, c == 26);
      end
      n_assert++;
      if (busy !== (c <= 25)) begin
        n_fail++; $display("FAIL %s busy c=%0d: got %b expected %b", name, c, busy, c <= 25);
      end
      if (c == 0) begin
        n_assert++;
        if (ready !== 1'b0) begin
          n_fail++; $display("FAIL %s ready at c=0: got %b expected 0", name, ready);
        end
      end
      if (rd_at >= 0 && c == rd_at) begin
        rd_en = 1'b1; rd_sel = 1'b1; rd_row = 3'd0; rd_col = 3'd0;
      end
      if (rd_at >= 0 && c == rd_at + 1) begin
        rd_en = 1'b0;
        n_assert++;
        if (rd_data !== rd_exp) begin
          n_fail++; $display("FAIL %s collision read c=%0d: got %h expected %h", name, rd_at, rd_data, rd_exp);
        end
      end
    end
    n_assert++;
    if (ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ready after run: got %b expected 1", name, ready);
    end
    drive_lanes(-10, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_assert++;
    if ({busy, ready, done, rd_valid, rd_data} !== 12'h000) begin
      n_fail++; $display("FAIL reset_state: got %b%b%b%b %h expected all 0", busy, ready, done, rd_valid, rd_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      drive_lanes(c, 1'b1);
      @(negedge clk);
    end
    n_assert++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre busy: got %b expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_assert++;
    if ({busy, ready, done, rd_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_mid: got %b%b%b%b expected 0000", busy, ready, done, rd_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_lanes(-10, 1'b0);
    for (int i = 1; i <= 8; i++) do_read(1'b1, i, i, 8'h00, "reset_udiag");
    n_assert++;
    if ({busy, ready, done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_idle: got %b%b%b expected 000", busy, ready, done);
    end
  endtask

  task automatic test_full_capture();
    run_capture(1'b0, 1'b0, -1, 8'h00, "full");
    do_read(1'b1, 1, 1, 8'h00, "U11");
    do_read(1'b1, 8, 8, 8'h07, "U88");
    do_read(1'b1, 5, 8, 8'h34, "U58");
    do_read(1'b0, 4, 1, 8'h70, "L41");
    do_read(1'b0, 8, 7, 8'h56, "L87");
    do_read(1'b1, 2, 4, 8'h21, "U24");
    do_read(1'b0, 6, 4, 8'h63, "L64");
    // Sweep every cell: the 0xFF filler must never appear.
    for (int s = 0; s < 2; s++)
      for (int r = 1; r <= 8; r++)
        for (int c = 1; c <= 8; c++) begin
          @(negedge clk);
          rd_en = 1'b1; rd_sel = s[0]; rd_row = 3'(r - 1); rd_col = 3'(c - 1);
          @(negedge clk);
          rd_en = 1'b0;
          n_assert++;
          if (rd_data === 8'hFF) begin
            n_fail++; $display("FAIL sweep sel=%0d (%0d,%0d): got %h expected not FF", s, r, c, rd_data);
          end
        end
  endtask

  task automatic test_band_edges();
    do_read(1'b0, 3, 3, 8'h01, "L33_unit");
    do_read(1'b0, 5, 1, 8'h00, "L51_out");
    do_read(1'b0, 1, 2, 8'h00, "L12_upper");
    do_read(1'b1, 1, 5, 8'h00, "U15_out");
    do_read(1'b1, 2, 1, 8'h00, "U21_lower");
  endtask

  task automatic test_start_ignored();
    run_capture(1'b0, 1'b1, -1, 8'h00, "stray_start");
    do_read(1'b1, 8, 8, 8'h07, "stray_U88");
    do_read(1'b0, 4, 1, 8'h70, "stray_L41");
  endtask

  task automatic test_restart_collision();
    // Run 2 from DONE with 0xAA lanes; U(1,1) read at c=4 sees the old 0x00.
    run_capture(1'b1, 1'b0, 4, 8'h00, "restart_c4");
    do_read(1'b1, 1, 1, 8'hAA, "restart_U11");
    do_read(1'b0, 8, 5, 8'hAA, "restart_L85");
    // Run 3 with the pattern; a read at c=5 already sees the new 0x00.
    run_capture(1'b0, 1'b0, 5, 8'h00, "restart_c5");
    do_read(1'b1, 5, 8, 8'h34, "rerun_U58");
  endtask

  initial begin
    test_reset();
    test_full_capture();
    test_band_edges();
    test_start_ignored();
    test_restart_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
